assoc_cache: RTL and testbench
==============================

# assoc_cache

Parametrised N-way set-associative, write-through, no-write-allocate data cache that sits between the pipeline's memory stage and data memory. It generalises the two-way single-word cache to configurable sets, ways and line length, with multi-word line refill. It adds true-LRU replacement, byte/halfword access with load extension per func3, misalignment detection, and an explicit request/acknowledge handshake to memory.

## Interface
Parameters:
- SETS, 4: number of sets; power of two, ≥2
- WAYS, 2: associativity; power of two, 1..8
- LINE_WORDS, 4: 32-bit words per line; power of two, 1..8
- ADDR_W, 32: byte address width

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high; one clock, synchronous reset, active-high
- cpu_req  in  1  access request; sampled only while busy=0
- cpu_we  in  1  1=store, 0=load
- cpu_addr  in  ADDR_W  byte address
- cpu_func3  in  3  RV32 width code: LB/LH/LW/LBU/LHU, SB/SH/SW
- cpu_wdata  in  32  store data, right-aligned
- cpu_rdata  out  32  extended load result; valid while cpu_done=1
- cpu_done  out  1  one-cycle completion pulse
- cpu_hit  out  1  qualifies cpu_done: access hit in cache
- cpu_err  out  1  one-cycle pulse on misaligned access or illegal func3
- busy  out  1  block cannot accept a request
- mem_req  out  1  memory request; held until mem_ack
- mem_we  out  1  memory write
- mem_addr  out  ADDR_W  word-aligned memory address
- mem_wdata  out  32  byte-lane-aligned write data
- mem_wstrb  out  4  byte strobes
- mem_rdata  in  32  read word; valid with mem_ack
- mem_ack  in  1  completes one memory word transfer

## Operation
- Address split: offset = log2(LINE_WORDS*4) bits, index = log2(SETS) bits, tag = the remaining bits.
- Alignment rule: halfword needs addr[0]=0; word needs addr[1:0]=0.
- Misaligned address or undefined func3: cpu_err pulses. No cache or memory access. cpu_done stays 0.
- States: IDLE, REFILL, WRITE, RESP.
- IDLE with accepted cpu_req:
  - Compare the tag against all ways in parallel.
  - Load hit: cpu_done=cpu_hit=1 next cycle with the extended word. Update LRU. Stay in IDLE.
  - Load miss: select a victim and go to REFILL.
  - Store: if it hits, merge the bytes into the line that cycle and update LRU. Then go to WRITE either way. cpu_hit records the hit status.
- REFILL:
  - Issue LINE_WORDS sequential reads, line_base+0, +4, …, one outstanding at a time.
  - Write each word into the victim line on its mem_ack.
  - After the last ack, set valid and tag, update LRU, and go to RESP.
- RESP: cpu_done=1, cpu_hit=0, cpu_rdata from the refilled line. Return to IDLE.
- WRITE:
  - mem_req=mem_we=1 with mem_addr=addr&~3.
  - mem_wdata holds the store data replicated across lanes.
  - mem_wstrb: SB = 1<<addr[1:0]; SH = 0011 or 1100; SW = 1111.
  - On mem_ack: cpu_done=1 and return to IDLE. Store misses never allocate.
- Victim selection: lowest-index invalid way; otherwise the way whose age = WAYS-1.
- LRU update: each set keeps one age of log2(WAYS) bits per way, always a permutation of 0..WAYS-1 among valid ways. On each access, the accessed way's age becomes 0, and every way whose age was below the old age increments. With WAYS=1 the LRU logic is absent.
- Load extension: LB/LH sign-extend; LBU/LHU zero-extend; the lane is selected by addr[1:0].

## Timing
- Reset values: all valid bits 0, ages reset to way index, state IDLE. All outputs are 0 (cpu_rdata=0, busy=0, mem_req=0).
- Reset during REFILL or WRITE: the transfer is abandoned and mem_req is 0 in the next cycle. The partial line is never valid and no cpu_done is issued.
- Load hit latency: 1 cycle, and busy stays 0. Back-to-back hits are accepted every cycle.
- Refill latency: a miss completes in 2 + Σ(ack delays) cycles after acceptance.
- busy=1 from the cycle after an accepted miss or store through the cycle cpu_done pulses.
- mem_addr, mem_we, mem_wdata and mem_wstrb stay stable while mem_req=1 and mem_ack=0. mem_req drops in the cycle after mem_ack, unless another refill word follows.
- mem_ack with mem_req=0 is ignored.
- A cpu_req arriving while busy=1 is ignored; the requester must hold it.

## Structure
- Package cache_pkg:
  - func3 localparams
  - state enum
  - clog2-derived width constants
  - pure functions load_extend(word, func3, lane) and store_strobe(func3, lane)
- Sub-module cache_lru: one instance per set. It holds the age vector and provides access-update and victim-output functions.
- Tag, valid and data arrays stay in the top module as flops.

## Test plan
- Test 1, cold load then hit (default parameters):
  - LW 0x0000_0040 with memory word = 0x1122_3344 → 4 reads at 0x40, 0x44, 0x48, 0x4C. Then cpu_done with cpu_hit=0 and rdata 0x1122_3344.
  - Repeating the load → cpu_done with cpu_hit=1 one cycle later, and no mem_req.
- Test 2, LRU eviction:
  - With WAYS=2, load tags A, B, then A again, all to set 1. Then load C to set 1 → B is evicted.
  - Load A → hit. Load B → miss.
- Test 3, store hit with extension:
  - Cached word 0x1122_3344. SB 0x80 at addr+1 → mem_wstrb=0010, mem_wdata=0x8080_8080.
  - Then LB at addr+1 → 0xFFFF_FF80. LBU at addr+1 → 0x0000_0080.
- Test 4, store miss does not allocate: SW to an uncached line → one memory write; a following LW misses.
- Test 5, misaligned access: LH at addr 0x41 → cpu_err pulse, no mem_req, state unchanged.
- Test 6, reset mid-refill: assert reset after 2 of 4 acks → mem_req=0 next cycle, and a reload of the same address misses.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared types, width constants and byte-lane helpers for the set-associative data cache.
package cache_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam int WORD_W = 32;
   localparam int STRB_W = WORD_W / 8;
   localparam int LANE_W = $clog2(STRB_W);

   typedef enum logic [1:0] {
      S_IDLE,
      S_REFILL,
      S_WRITE,
      S_RESP
   } state_t;

   // A width of at least one bit keeps single-way / single-word builds legal.
   function automatic int clog2_min1(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic logic access_ok(input logic we, input logic [2:0] f3,
                                      input logic [LANE_W-1:0] lane);
      logic legal;
      case (f3)
         F3_B, F3_H, F3_W: legal = 1'b1;
         F3_BU, F3_HU:     legal = !we;
         default:          legal = 1'b0;
      endcase
      case (f3[1:0])
         2'b01:   return legal && !lane[0];
         2'b10:   return legal && (lane == 2'b00);
         default: return legal;
      endcase
   endfunction

   function automatic logic [WORD_W-1:0] load_extend(input logic [WORD_W-1:0] word,
                                                     input logic [2:0] f3,
                                                     input logic [LANE_W-1:0] lane);
      logic [WORD_W-1:0] sh;
      sh = word >> {lane, 3'b000};
      case (f3)
         F3_B:    return {{24{sh[7]}}, sh[7:0]};
         F3_H:    return {{16{sh[15]}}, sh[15:0]};
         F3_BU:   return {24'b0, sh[7:0]};
         F3_HU:   return {16'b0, sh[15:0]};
         default: return word;
      endcase
   endfunction

   function automatic logic [STRB_W-1:0] store_strobe(input logic [2:0] f3,
                                                      input logic [LANE_W-1:0] lane);
      case (f3)
         F3_B:    return 4'b0001 << lane;
         F3_H:    return lane[1] ? 4'b1100 : 4'b0011;
         F3_W:    return 4'b1111;
         default: return 4'b0000;
      endcase
   endfunction

   function automatic logic [WORD_W-1:0] store_replicate(input logic [2:0] f3,
                                                         input logic [WORD_W-1:0] wd);
      case (f3)
         F3_B:    return {4{wd[7:0]}};
         F3_H:    return {2{wd[15:0]}};
         default: return wd;
      endcase
   endfunction

endpackage

// File: rtl/cache_lru.sv
// True-LRU age vector for one cache set: ages form a permutation, oldest way is the victim.
module cache_lru
   import cache_pkg::*;
#(
   parameter  int WAYS  = 2,
   localparam int WAY_W = clog2_min1(WAYS)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             upd,
   input  logic [WAY_W-1:0] upd_way,
   output logic [WAY_W-1:0] victim
);

   generate
      if (WAYS > 1) begin : g_lru
         logic [WAY_W-1:0] age [WAYS];
         logic [WAY_W-1:0] upd_age;

         assign upd_age = age[upd_way];

         // Accessed way becomes youngest; only ways younger than it age by one.
         always_ff @(posedge clk) begin
            if (reset) begin
               for (int w = 0; w < WAYS; w++) age[w] <= WAY_W'(w);
            end else if (upd) begin
               for (int w = 0; w < WAYS; w++) begin
                  if (WAY_W'(w) == upd_way)    age[w] <= '0;
                  else if (age[w] < upd_age) age[w] <= age[w] + 1'b1;
               end
            end
         end

         always_comb begin
            victim = '0;
            for (int w = 0; w < WAYS; w++)
               if (age[w] == WAY_W'(WAYS - 1)) victim = WAY_W'(w);
         end
      end else begin : g_direct
         assign victim = '0;
      end
   endgenerate

endmodule

// File: rtl/assoc_cache.sv
// N-way set-associative write-through, no-write-allocate data cache with multi-word line refill.
module assoc_cache
   import cache_pkg::*;
#(
   parameter int SETS       = 4,
   parameter int WAYS       = 2,
   parameter int LINE_WORDS = 4,
   parameter int ADDR_W     = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [2:0]        cpu_func3,
   input  logic [31:0]       cpu_wdata,
   output logic [31:0]       cpu_rdata,
   output logic              cpu_done,
   output logic              cpu_hit,
   output logic              cpu_err,
   output logic              busy,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic [3:0]        mem_wstrb,
   input  logic [31:0]       mem_rdata,
   input  logic              mem_ack
);

   localparam int OFF_W  = $clog2(LINE_WORDS * 4);
   localparam int IDX_W  = $clog2(SETS);
   localparam int TAG_W  = ADDR_W - OFF_W - IDX_W;
   localparam int WAY_W  = clog2_min1(WAYS);
   localparam int WSEL_W = clog2_min1(LINE_WORDS);

   function automatic logic [IDX_W-1:0] idx_of(input logic [ADDR_W-1:0] a);
      return a[OFF_W +: IDX_W];
   endfunction

   function automatic logic [TAG_W-1:0] tag_of(input logic [ADDR_W-1:0] a);
      return a[ADDR_W-1 -: TAG_W];
   endfunction

   function automatic logic [WSEL_W-1:0] word_of(input logic [ADDR_W-1:0] a);
      return WSEL_W'((a >> 2) & ADDR_W'(LINE_WORDS - 1));
   endfunction

   logic              valid   [SETS][WAYS];
   logic [TAG_W-1:0]  tag_arr [SETS][WAYS];
   logic [31:0]       data    [SETS][WAYS][LINE_WORDS];

   state_t            state, state_nx;
   logic [ADDR_W-1:0] r_addr;
   logic [2:0]        r_func3;
   logic [31:0]       r_wdata;
   logic [WAY_W-1:0]  r_way;
   logic              r_hit;
   logic [31:0]       r_word;
   logic [WSEL_W-1:0] fill_cnt;
   logic              done_q, hit_q, err_q;
   logic [31:0]       rdata_q;

   logic [IDX_W-1:0]  c_idx, r_idx;
   logic [TAG_W-1:0]  c_tag, r_tag;
   logic [WSEL_W-1:0] c_word, r_wsel;
   logic [1:0]        c_lane;
   logic              accept, c_ok, hit_any, inv_any, fill_last;
   logic [WAY_W-1:0]  hit_way, inv_way, vict_way;
   logic [WAY_W-1:0]  lru_victim [SETS];
   logic [3:0]        c_strb;
   logic [31:0]       c_rep;
   logic [ADDR_W-1:0] line_base;

   assign c_idx     = idx_of(cpu_addr);
   assign c_tag     = tag_of(cpu_addr);
   assign c_word    = word_of(cpu_addr);
   assign c_lane    = cpu_addr[1:0];
   assign r_idx     = idx_of(r_addr);
   assign r_tag     = tag_of(r_addr);
   assign r_wsel    = word_of(r_addr);
   assign accept    = cpu_req && (state == S_IDLE);
   assign c_ok      = access_ok(cpu_we, cpu_func3, c_lane);
   assign c_strb    = store_strobe(cpu_func3, c_lane);
   assign c_rep     = store_replicate(cpu_func3, cpu_wdata);
   assign fill_last = (fill_cnt == WSEL_W'(LINE_WORDS - 1));
   assign line_base = {r_addr[ADDR_W-1:OFF_W], OFF_W'(0)};

   // Parallel tag compare; the downward scan leaves the lowest matching / invalid way.
   always_comb begin
      hit_any = 1'b0;
      hit_way = '0;
      inv_any = 1'b0;
      inv_way = '0;
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (valid[c_idx][w] && (tag_arr[c_idx][w] == c_tag)) begin
            hit_any = 1'b1;
            hit_way = WAY_W'(w);
         end
         if (!valid[c_idx][w]) begin
            inv_any = 1'b1;
            inv_way = WAY_W'(w);
         end
      end
      vict_way = inv_any ? inv_way : lru_victim[c_idx];
   end

   logic             lru_upd;
   logic [IDX_W-1:0] lru_idx;
   logic [WAY_W-1:0] lru_way;

   always_comb begin
      lru_upd = 1'b0;
      lru_idx = c_idx;
      lru_way = hit_way;
      if (accept && c_ok && hit_any) begin
         lru_upd = 1'b1;
      end else if ((state == S_REFILL) && mem_ack && fill_last) begin
         lru_upd = 1'b1;
         lru_idx = r_idx;
         lru_way = r_way;
      end
   end

   generate
      for (genvar s = 0; s < SETS; s++) begin : g_set
         cache_lru #(.WAYS(WAYS)) u_lru (
            .clk     (clk),
            .reset   (reset),
            .upd     (lru_upd && (lru_idx == IDX_W'(s))),
            .upd_way (lru_way),
            .victim  (lru_victim[s])
         );
      end
   endgenerate

   always_comb begin
      state_nx  = state;
      busy      = 1'b1;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      mem_wstrb = '0;
      case (state)
         S_IDLE: begin
            busy = 1'b0;
            if (accept && c_ok) begin
               if (cpu_we)        state_nx = S_WRITE;
               else if (!hit_any) state_nx = S_REFILL;
            end
         end
         S_REFILL: begin
            mem_req  = 1'b1;
            mem_addr = line_base | (ADDR_W'(fill_cnt) << 2);
            if (mem_ack && fill_last) state_nx = S_RESP;
         end
         S_WRITE: begin
            mem_req   = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = {r_addr[ADDR_W-1:2], 2'b00};
            mem_wdata = store_replicate(r_func3, r_wdata);
            mem_wstrb = store_strobe(r_func3, r_addr[1:0]);
            if (mem_ack) state_nx = S_IDLE;
         end
         S_RESP:  state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   assign cpu_done  = done_q || (state == S_RESP) || ((state == S_WRITE) && mem_ack);
   assign cpu_hit   = hit_q || ((state == S_WRITE) && mem_ack && r_hit);
   assign cpu_err   = err_q;
   assign cpu_rdata = rdata_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= S_IDLE;
         done_q   <= 1'b0;
         hit_q    <= 1'b0;
         err_q    <= 1'b0;
         rdata_q  <= '0;
         fill_cnt <= '0;
         for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++) valid[s][w] <= 1'b0;
      end else begin
         state  <= state_nx;
         done_q <= 1'b0;
         hit_q  <= 1'b0;
         err_q  <= 1'b0;
         if (accept) begin
            if (!c_ok) begin
               err_q <= 1'b1;
            end else if (!cpu_we && hit_any) begin
               done_q  <= 1'b1;
               hit_q   <= 1'b1;
               rdata_q <= load_extend(data[c_idx][hit_way][c_word], cpu_func3, c_lane);
            end else if (!cpu_we) begin
               // Victim is invalidated up front so an abandoned refill never leaves a stale-tag line.
               valid[c_idx][vict_way] <= 1'b0;
               fill_cnt               <= '0;
            end
         end
         if ((state == S_REFILL) && mem_ack) begin
            fill_cnt <= fill_cnt + 1'b1;
            if (fill_last) begin
               valid[r_idx][r_way] <= 1'b1;
               rdata_q <= load_extend((fill_cnt == r_wsel) ? mem_rdata : r_word,
                                      r_func3, r_addr[1:0]);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         if (accept) begin
            r_addr  <= cpu_addr;
            r_func3 <= cpu_func3;
            r_wdata <= cpu_wdata;
            r_hit   <= hit_any;
            r_way   <= vict_way;
            if (c_ok && cpu_we && hit_any)
               for (int b = 0; b < 4; b++)
                  if (c_strb[b]) data[c_idx][hit_way][c_word][8*b +: 8] <= c_rep[8*b +: 8];
         end
         if ((state == S_REFILL) && mem_ack) begin
            data[r_idx][r_way][fill_cnt] <= mem_rdata;
            if (fill_cnt == r_wsel) r_word <= mem_rdata;
            if (fill_last) tag_arr[r_idx][r_way] <= r_tag;
         end
      end
   end

endmodule

// File: tb/tb_assoc_cache.sv
// Directed scoreboard bench for assoc_cache against a word-addressed memory model with ack responder.
module tb_assoc_cache;

   logic        clk = 1'b0;
   logic        reset;
   logic        cpu_req, cpu_we;
   logic [31:0] cpu_addr;
   logic [2:0]  cpu_func3;
   logic [31:0] cpu_wdata, cpu_rdata;
   logic        cpu_done, cpu_hit, cpu_err, busy;
   logic        mem_req, mem_we, mem_ack;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_wstrb;

   always #5 clk = ~clk;

   assoc_cache #(.SETS(4), .WAYS(2), .LINE_WORDS(4), .ADDR_W(32)) dut (
      .clk       (clk),
      .reset     (reset),
      .cpu_req   (cpu_req),
      .cpu_we    (cpu_we),
      .cpu_addr  (cpu_addr),
      .cpu_func3 (cpu_func3),
      .cpu_wdata (cpu_wdata),
      .cpu_rdata (cpu_rdata),
      .cpu_done  (cpu_done),
      .cpu_hit   (cpu_hit),
      .cpu_err   (cpu_err),
      .busy      (busy),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_wstrb (mem_wstrb),
      .mem_rdata (mem_rdata),
      .mem_ack   (mem_ack)
   );

   int n_cmp = 0;
   int n_bad = 0;

   logic [31:0] mem [0:4095];
   int          ack_budget = -1;
   int          ack_dly    = 0;
   int          n_acks     = 0;
   int          n_writes   = 0;
   int          req_cycles = 0;
   logic [31:0] rd_q [$];
   logic [31:0] last_w_addr, last_w_data;
   logic [3:0]  last_w_strb;

   typedef struct packed {
      logic        err;
      logic        hit;
      logic [31:0] rdata;
   } exp_t;
   exp_t exp_q [$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] ext(input logic [31:0] w, input logic [2:0] f3,
                                       input logic [1:0] lane);
      logic [7:0]  b;
      logic [15:0] h;
      b = w[8*lane +: 8];
      h = lane[1] ? w[31:16] : w[15:0];
      case (f3)
         3'b000:  return {{24{b[7]}}, b};
         3'b001:  return {{16{h[15]}}, h};
         3'b010:  return w;
         3'b100:  return {24'h0, b};
         3'b101:  return {16'h0, h};
         default: return 32'h0;
      endcase
   endfunction

   // Memory responder: drives ack a little after the rising edge so it is stable by the next edge.
   initial begin
      int dcnt;
      dcnt      = 0;
      mem_ack   = 1'b0;
      mem_rdata = '0;
      forever begin
         @(posedge clk);
         #1;
         mem_ack   = 1'b0;
         mem_rdata = '0;
         if (mem_req) req_cycles++;
         if (mem_req && !reset && ack_budget != 0) begin
            if (dcnt < ack_dly) begin
               dcnt++;
            end else begin
               dcnt    = 0;
               mem_ack = 1'b1;
               n_acks++;
               if (ack_budget > 0) ack_budget--;
               if (mem_we) begin
                  for (int b = 0; b < 4; b++)
                     if (mem_wstrb[b]) mem[mem_addr[13:2]][8*b +: 8] = mem_wdata[8*b +: 8];
                  n_writes++;
                  last_w_addr = mem_addr;
                  last_w_data = mem_wdata;
                  last_w_strb = mem_wstrb;
               end else begin
                  mem_rdata = mem[mem_addr[13:2]];
                  rd_q.push_back(mem_addr);
               end
            end
         end
      end
   end

   task automatic access(input string tag, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic exp_err, input logic exp_hit);
      exp_t e;
      int   waited, rq0;
      e.err   = exp_err;
      e.hit   = exp_hit;
      e.rdata = (we || exp_err) ? 32'h0 : ext(mem[addr[13:2]], f3, addr[1:0]);
      exp_q.push_back(e);
      rq0 = req_cycles;
      @(negedge clk);
      cpu_req   = 1'b1;
      cpu_we    = we;
      cpu_func3 = f3;
      cpu_addr  = addr;
      cpu_wdata = wd;
      @(posedge clk);
      @(negedge clk);
      cpu_req = 1'b0;
      chk({tag, ".busy"}, 32'(busy), 32'(!exp_err && (we || !exp_hit)));
      waited = 0;
      while (!cpu_done && !cpu_err && waited < 100) begin
         @(negedge clk);
         waited++;
      end
      e = exp_q.pop_front();
      chk({tag, ".complete"}, 32'(cpu_done || cpu_err), 32'd1);
      chk({tag, ".err"}, 32'(cpu_err), 32'(e.err));
      chk({tag, ".done"}, 32'(cpu_done), 32'(!e.err));
      if (!e.err) chk({tag, ".hit"}, 32'(cpu_hit), 32'(e.hit));
      if (!e.err && !we) chk({tag, ".rdata"}, cpu_rdata, e.rdata);
      if (e.err || (!we && e.hit)) begin
         chk({tag, ".latency"}, 32'(waited), 32'd0);
         chk({tag, ".no_mem_req"}, 32'(req_cycles - rq0), 32'd0);
      end
   endtask

   initial begin
      int a0, w0, waited;
      for (int i = 0; i < 4096; i++) mem[i] = 32'(i) * 32'h9E37_79B1;
      mem[32'h40 >> 2] = 32'h1122_3344;
      reset     = 1'b1;
      cpu_req   = 1'b0;
      cpu_we    = 1'b0;
      cpu_addr  = '0;
      cpu_func3 = '0;
      cpu_wdata = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst.rdata", cpu_rdata, 32'h0);
      chk("rst.done", 32'(cpu_done), 32'h0);
      chk("rst.hit", 32'(cpu_hit), 32'h0);
      chk("rst.err", 32'(cpu_err), 32'h0);
      chk("rst.busy", 32'(busy), 32'h0);
      chk("rst.mem_req", 32'(mem_req), 32'h0);
      chk("rst.mem_we", 32'(mem_we), 32'h0);
      chk("rst.mem_addr", mem_addr, 32'h0);
      chk("rst.mem_wstrb", 32'(mem_wstrb), 32'h0);
      reset = 1'b0;

      // Test 1: cold load fetches the whole line, repeat hits.
      rd_q.delete();
      access("t1.cold", 1'b0, 3'b010, 32'h40, 32'h0, 1'b0, 1'b0);
      chk("t1.nreads", 32'(rd_q.size()), 32'd4);
      for (int i = 0; i < 4; i++)
         if (i < rd_q.size()) chk("t1.read_addr", rd_q[i], 32'h40 + 32'(4 * i));
      access("t1.hit", 1'b0, 3'b010, 32'h40, 32'h0, 1'b0, 1'b1);

      // Back-to-back hits on consecutive cycles.
      @(negedge clk);
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_func3 = 3'b010; cpu_addr = 32'h40;
      @(posedge clk);
      @(negedge clk);
      chk("b2b.busy", 32'(busy), 32'h0);
      chk("b2b.done0", 32'(cpu_done && cpu_hit), 32'd1);
      chk("b2b.rdata0", cpu_rdata, mem[32'h40 >> 2]);
      cpu_addr = 32'h44;
      @(posedge clk);
      @(negedge clk);
      cpu_req = 1'b0;
      chk("b2b.done1", 32'(cpu_done && cpu_hit), 32'd1);
      chk("b2b.rdata1", cpu_rdata, mem[32'h44 >> 2]);

      // Test 2: LRU eviction in set 1 (A=0x10, B=0x50, C=0x90), with slower memory.
      ack_dly = 2;
      access("t2.A_miss", 1'b0, 3'b010, 32'h10, 32'h0, 1'b0, 1'b0);
      access("t2.B_miss", 1'b0, 3'b010, 32'h54, 32'h0, 1'b0, 1'b0);
      access("t2.A_hit", 1'b0, 3'b010, 32'h18, 32'h0, 1'b0, 1'b1);
      access("t2.C_miss", 1'b0, 3'b010, 32'h9C, 32'h0, 1'b0, 1'b0);
      access("t2.A_hit2", 1'b0, 3'b010, 32'h14, 32'h0, 1'b0, 1'b1);
      access("t2.B_evicted", 1'b0, 3'b010, 32'h50, 32'h0, 1'b0, 1'b0);
      access("t2.C_evicted", 1'b0, 3'b010, 32'h90, 32'h0, 1'b0, 1'b0);
      ack_dly = 0;

      // Test 3: store hits with byte/halfword lanes and load extension.
      access("t3.sb", 1'b1, 3'b000, 32'h41, 32'h0000_0080, 1'b0, 1'b1);
      chk("t3.sb.addr", last_w_addr, 32'h40);
      chk("t3.sb.wstrb", 32'(last_w_strb), 32'h2);
      chk("t3.sb.wdata", last_w_data, 32'h8080_8080);
      access("t3.lb", 1'b0, 3'b000, 32'h41, 32'h0, 1'b0, 1'b1);
      chk("t3.lb.value", cpu_rdata, 32'hFFFF_FF80);
      access("t3.lbu", 1'b0, 3'b100, 32'h41, 32'h0, 1'b0, 1'b1);
      chk("t3.lbu.value", cpu_rdata, 32'h0000_0080);
      access("t3.lh", 1'b0, 3'b001, 32'h40, 32'h0, 1'b0, 1'b1);
      chk("t3.lh.value", cpu_rdata, 32'hFFFF_8044);
      access("t3.lhu", 1'b0, 3'b101, 32'h42, 32'h0, 1'b0, 1'b1);
      chk("t3.lhu.value", cpu_rdata, 32'h0000_1122);
      access("t3.sh", 1'b1, 3'b001, 32'h46, 32'h1234_BEEF, 1'b0, 1'b1);
      chk("t3.sh.wstrb", 32'(last_w_strb), 32'hC);
      chk("t3.sh.wdata", last_w_data, 32'hBEEF_BEEF);
      access("t3.lw_merged", 1'b0, 3'b010, 32'h44, 32'h0, 1'b0, 1'b1);

      // Test 4: store miss writes through without allocating.
      ack_dly = 1;
      w0 = n_writes;
      access("t4.sw_miss", 1'b1, 3'b010, 32'h200, 32'hDEAD_BEEF, 1'b0, 1'b0);
      chk("t4.nwrites", 32'(n_writes - w0), 32'd1);
      chk("t4.wstrb", 32'(last_w_strb), 32'hF);
      chk("t4.addr", last_w_addr, 32'h200);
      access("t4.lw_miss", 1'b0, 3'b010, 32'h200, 32'h0, 1'b0, 1'b0);
      chk("t4.value", cpu_rdata, 32'hDEAD_BEEF);
      ack_dly = 0;

      // Test 5: misaligned and illegal accesses.
      access("t5.lh_odd", 1'b0, 3'b001, 32'h41, 32'h0, 1'b1, 1'b0);
      access("t5.lw_half", 1'b0, 3'b010, 32'h42, 32'h0, 1'b1, 1'b0);
      access("t5.sh_odd", 1'b1, 3'b001, 32'h43, 32'h0, 1'b1, 1'b0);
      access("t5.bad_load", 1'b0, 3'b011, 32'h40, 32'h0, 1'b1, 1'b0);
      access("t5.bad_store", 1'b1, 3'b100, 32'h40, 32'h0, 1'b1, 1'b0);
      access("t5.still_hit", 1'b0, 3'b010, 32'h40, 32'h0, 1'b0, 1'b1);

      // Test 6: reset after two of four refill words.
      ack_budget = 2;
      a0 = n_acks;
      @(negedge clk);
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_func3 = 3'b010; cpu_addr = 32'h308;
      @(posedge clk);
      @(negedge clk);
      cpu_req = 1'b0;
      waited = 0;
      while (n_acks < a0 + 2 && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      chk("t6.acks", 32'(n_acks - a0), 32'd2);
      @(negedge clk);
      chk("t6.stalled", 32'(mem_req && busy && !cpu_done), 32'd1);
      reset = 1'b1;
      @(posedge clk);
      #1;
      chk("t6.mem_req", 32'(mem_req), 32'h0);
      chk("t6.busy", 32'(busy), 32'h0);
      @(negedge clk);
      chk("t6.done", 32'(cpu_done), 32'h0);
      reset      = 1'b0;
      ack_budget = -1;
      access("t6.reload", 1'b0, 3'b010, 32'h308, 32'h0, 1'b0, 1'b0);
      access("t6.cold40", 1'b0, 3'b010, 32'h40, 32'h0, 1'b0, 1'b0);
      access("t6.rehit", 1'b0, 3'b010, 32'h300, 32'h0, 1'b0, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog expired");
   end

endmodule
